risc_ctrl_seq: RTL and testbench

- Eight-phase instruction sequencer for the VeriRISC CPU.
- Steps a 3-bit phase counter through fetch and execute. Decodes the current phase together with the instruction opcode and the accumulator zero flag.
- Drives the address-mux select (`sel`: 1 = program counter, 0 = IR operand address) and all load, increment, read, write and bus-enable strobes.
- Sits between the instruction register / ALU zero flag and the PC, IR, AC, memory and address mux.

---
 rtl/risc_ctrl_seq.sv | 112 +++++++++++
 tb/tb_risc_ctrl_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/risc_ctrl_seq.sv
// risc_ctrl_seq: eight-phase VeriRISC fetch/execute sequencer with opcode/zero decode
module risc_ctrl_seq #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e
);
    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    phase_t state, state_nx;
    logic   halted, halted_nx;
    logic   alu_op, is_hlt, is_skz, is_sto, is_jmp;

    assign alu_op = (opcode == ADD) | (opcode == AND) | (opcode == XOR) | (opcode == LDA);
    assign is_hlt = opcode == HLT;
    assign is_skz = opcode == SKZ;
    assign is_sto = opcode == STO;
    assign is_jmp = opcode == JMP;
    assign phase  = state;

    // Phase and halted-flag registers; reset wins from any phase, halted or not
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= state_nx;
            halted <= halted_nx;
        end
    end

    // Next phase plus combinational strobe decode from phase, opcode, zero and halted
    always_comb begin
        halted_nx = halted | (HALT_STICKY && state == OP_ADDR && is_hlt);
        state_nx  = halted_nx ? OP_ADDR : phase_t'(state + 3'd1);
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (state)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: rd = alu_op;
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = is_skz & zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    inc_pc = is_jmp;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: sel = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_ctrl_seq.sv
// tb_risc_ctrl_seq: directed checks of the VeriRISC sequencer phase decode
module tb_risc_ctrl_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd2;
    logic       zero = 1'b0;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    int         checks = 0;
    int         errors = 0;

    // Expected vector bit order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
    localparam logic [8:0] F0 = 9'b100000000;
    localparam logic [8:0] F1 = 9'b110000000;
    localparam logic [8:0] F2 = 9'b111000000;
    localparam logic [8:0] NO = 9'b000000000;

    risc_ctrl_seq #(.HALT_STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .phase(phase),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
        .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] ph, input logic [8:0] e);
        logic [11:0] obs, exp;
        obs = {phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
        exp = {ph, e};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                   tag, obs[11:9], obs[8:0], exp[11:9], exp[8:0]);
        end
    endtask

    // Runs one instruction from phase 0 through phase 7, ending back at phase 0
    task automatic exec(input string tag, input logic [2:0] op, input logic z,
                        input logic [8:0] e4, input logic [8:0] e5,
                        input logic [8:0] e6, input logic [8:0] e7);
        opcode = op;
        zero   = z;
        #1;
        chk({tag, "_p0"}, 3'd0, F0); step();
        chk({tag, "_p1"}, 3'd1, F1); step();
        chk({tag, "_p2"}, 3'd2, F2); step();
        chk({tag, "_p3"}, 3'd3, F2); step();
        chk({tag, "_p4"}, 3'd4, e4); step();
        chk({tag, "_p5"}, 3'd5, e5); step();
        chk({tag, "_p6"}, 3'd6, e6); step();
        chk({tag, "_p7"}, 3'd7, e7); step();
    endtask

    initial begin
        step();
        step();
        chk("reset", 3'd0, F0);
        rst = 1'b0;
        exec("add", 3'd2, 1'b0, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000);
        exec("lda", 3'd5, 1'b1, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000);
        exec("sto", 3'd6, 1'b0, 9'b000010000, NO, 9'b000000001, 9'b000000011);
        exec("jmp", 3'd7, 1'b0, 9'b000010000, NO, 9'b000000100, 9'b000010100);
        exec("skz1", 3'd1, 1'b1, 9'b000010000, NO, 9'b000010000, NO);
        exec("skz0", 3'd1, 1'b0, 9'b000010000, NO, NO, NO);
        exec("and", 3'd3, 1'b0, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000);
        // zero toggles mid-phase on SKZ take effect with no latency
        opcode = 3'd1;
        zero   = 1'b0;
        repeat (6) step();
        chk("skz_live0", 3'd6, NO);
        zero = 1'b1;
        #1;
        chk("skz_live1", 3'd6, 9'b000010000);
        step();
        step();
        chk("skz_wrap", 3'd0, F0);
        // sticky halt
        opcode = 3'd0;
        zero   = 1'b0;
        #1;
        repeat (4) step();
        chk("hlt_p4", 3'd4, 9'b000110000);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("halted_%0d", i), 3'd4, 9'b000100000);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hlt_reset", 3'd0, F0);
        // reset in the middle of a STO
        opcode = 3'd6;
        #1;
        repeat (6) step();
        chk("sto_mid_p6", 3'd6, 9'b000000001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset", 3'd0, F0);
        exec("resume", 3'd2, 1'b0, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000);
        chk("resume_wrap", 3'd0, F0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
